// File: rtl/imem_axil_rom_if.sv
// AXI-lite read-only channel pair (AR + R) between the fetch stage and its instruction memory.
interface imem_axil_rom_if;
  logic        ARVALID;
  logic [31:0] ARADDR;
  logic        ARREADY;
  logic        RVALID;
  logic        RREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;

  modport master (
    output ARVALID, ARADDR, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, RREADY,
    output ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/imem_axil_rom.sv
// Instruction ROM behind an AXI-lite read port: one outstanding fetch, programmable wait,
// 64-bit doubleword responses, preloadable through a side write port.
module imem_axil_rom #(
  parameter logic [63:0] BASE       = 64'h0 + 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_axil_rom_if.slave        bus,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [63:0]           ld_data,
  output logic [31:0]           rd_cnt
);
  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'd8 << DEPTH_LOG2;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [63:0] mem [DEPTH];

  state_t                state_reg;
  logic [DEPTH_LOG2-1:0] idx_reg;
  logic                  in_range_reg;
  logic [3:0]            cnt_reg;
  logic                  arready_reg;
  logic                  rvalid_reg;
  logic [63:0]           rdata_reg;
  logic [1:0]            rresp_reg;
  logic [31:0]           rd_cnt_reg;

  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] ar_idx;
  logic                  ar_in_range;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  capture;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic                  cap_in_range;
  logic                  cap_fwd;

  always_comb begin
    off         = bus.ARADDR - BASE[31:0];
    ar_idx      = off[DEPTH_LOG2+2:3];
    ar_in_range = ({32'h0, bus.ARADDR} >= BASE) && ({1'b0, off} < SPAN);
    ar_fire     = bus.ARVALID && arready_reg;
    r_fire      = rvalid_reg && bus.RREADY;

    // With zero wait the accept edge is also the capture edge, so a preload
    // landing on the same word in that cycle is forwarded to keep it visible.
    capture      = 1'b0;
    cap_idx      = idx_reg;
    cap_in_range = in_range_reg;
    cap_fwd      = 1'b0;
    if (state_reg == IDLE) begin
      capture      = ar_fire && (LAT == 4'd0);
      cap_idx      = ar_idx;
      cap_in_range = ar_in_range;
      cap_fwd      = ld_en && (ld_idx == ar_idx);
    end else if (state_reg == WAIT) begin
      capture = (cnt_reg == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      in_range_reg <= 1'b0;
      cnt_reg      <= 4'd0;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= 64'h0;
      rresp_reg    <= 2'b00;
      rd_cnt_reg   <= 32'h0;
    end else begin
      if (capture) begin
        rvalid_reg <= 1'b1;
        if (!cap_in_range) begin
          rdata_reg <= 64'h0;
          rresp_reg <= 2'b11;
        end else if (cap_fwd) begin
          rdata_reg <= ld_data;
          rresp_reg <= 2'b00;
        end else begin
          rdata_reg <= mem[cap_idx];
          rresp_reg <= 2'b00;
        end
      end

      case (state_reg)
        IDLE: begin
          arready_reg <= 1'b1;
          if (ar_fire) begin
            idx_reg      <= ar_idx;
            in_range_reg <= ar_in_range;
            cnt_reg      <= LAT;
            arready_reg  <= 1'b0;
            state_reg    <= (LAT == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (r_fire) begin
            state_reg   <= IDLE;
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            rd_cnt_reg  <= rd_cnt_reg + 32'd1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          arready_reg <= 1'b0;
          rvalid_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ARREADY = arready_reg;
  assign bus.RVALID  = rvalid_reg;
  assign bus.RDATA   = rdata_reg;
  assign bus.RRESP   = rresp_reg;
  assign rd_cnt      = rd_cnt_reg;
endmodule

// File: tb/tb_imem_axil_rom.sv
// Directed bench for imem_axil_rom: three instances (LATENCY 1, 0, 4) sharing clock, reset and preload port.
module tb_imem_axil_rom;
  localparam logic [63:0] D0    = 64'h00000013_00100093;
  localparam logic [63:0] D1    = 64'h11111111_22222222;
  localparam logic [63:0] D5    = 64'h00000000_55555555;
  localparam logic [63:0] D6    = 64'h00000000_00006666;
  localparam logic [63:0] DLAST = 64'hFFFF0000_ABCD0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [11:0] ld_idx;
  logic [63:0] ld_data;
  logic        arvalid [3];
  logic [31:0] araddr  [3];
  logic        rready  [3];
  logic [31:0] rd_cnt  [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_axil_rom_if bus0 ();
  imem_axil_rom_if bus1 ();
  imem_axil_rom_if bus2 ();

  assign bus0.ARVALID = arvalid[0];
  assign bus0.ARADDR  = araddr[0];
  assign bus0.RREADY  = rready[0];
  assign bus1.ARVALID = arvalid[1];
  assign bus1.ARADDR  = araddr[1];
  assign bus1.RREADY  = rready[1];
  assign bus2.ARVALID = arvalid[2];
  assign bus2.ARADDR  = araddr[2];
  assign bus2.RREADY  = rready[2];

  imem_axil_rom #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .bus(bus0),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .rd_cnt(rd_cnt[0])
  );
  imem_axil_rom #(.LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .bus(bus1),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .rd_cnt(rd_cnt[1])
  );
  imem_axil_rom #(.LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .bus(bus2),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .rd_cnt(rd_cnt[2])
  );

  function automatic logic get_arready(input int s);
    case (s)
      0:       return bus0.ARREADY;
      1:       return bus1.ARREADY;
      default: return bus2.ARREADY;
    endcase
  endfunction

  function automatic logic get_rvalid(input int s);
    case (s)
      0:       return bus0.RVALID;
      1:       return bus1.RVALID;
      default: return bus2.RVALID;
    endcase
  endfunction

  function automatic logic [63:0] get_rdata(input int s);
    case (s)
      0:       return bus0.RDATA;
      1:       return bus1.RDATA;
      default: return bus2.RDATA;
    endcase
  endfunction

  function automatic logic [1:0] get_rresp(input int s);
    case (s)
      0:       return bus0.RRESP;
      1:       return bus1.RRESP;
      default: return bus2.RRESP;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] i, input logic [63:0] d);
    ld_en   = 1'b1;
    ld_idx  = i;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  // One complete read: returns data, response and cycles from AR handshake to first RVALID.
  task automatic fetch(input int s, input logic [31:0] addr,
                       output logic [63:0] data, output logic [1:0] resp, output int lat);
    int guard;
    arvalid[s] = 1'b1;
    araddr[s]  = addr;
    guard = 0;
    while (!get_arready(s) && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    arvalid[s] = 1'b0;
    lat = 1;
    while (!get_rvalid(s) && lat < 40) begin
      tick();
      lat++;
    end
    data = get_rdata(s);
    resp = get_rresp(s);
    rready[s] = 1'b1;
    tick();
    rready[s] = 1'b0;
    $display("[TB] fetch dut%0d addr %h -> data %h resp %0d lat %0d", s, addr, data, resp, lat);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  resp;
  } vec_t;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [9];
    logic [63:0] d;
    logic [1:0]  r;
    int          lat;
    int          seen;
    logic [31:0] exp_cnt [3];

    vecs[0] = '{32'h8000_0000, D0,    2'b00};
    vecs[1] = '{32'h8000_0004, D0,    2'b00};
    vecs[2] = '{32'h8000_0008, D1,    2'b00};
    vecs[3] = '{32'h8000_0028, D5,    2'b00};
    vecs[4] = '{32'h8000_7FF8, DLAST, 2'b00};
    vecs[5] = '{32'h8000_7FFF, DLAST, 2'b00};
    vecs[6] = '{32'h7FFF_FFF8, 64'h0, 2'b11};
    vecs[7] = '{32'h8000_8000, 64'h0, 2'b11};
    vecs[8] = '{32'h0000_0000, 64'h0, 2'b11};

    rst     = 1'b1;
    ld_en   = 1'b0;
    ld_idx  = '0;
    ld_data = '0;
    for (int i = 0; i < 3; i++) begin
      arvalid[i] = 1'b0;
      araddr[i]  = '0;
      rready[i]  = 1'b0;
      exp_cnt[i] = '0;
    end

    // Preload while reset is held
    tick();
    preload(12'd0,   D0);
    preload(12'd1,   D1);
    preload(12'd5,   D5);
    preload(12'd6,   D6);
    preload(12'hFFF, DLAST);
    tick();

    check("rst arready", get_arready(0), 0);
    check("rst rvalid",  get_rvalid(0),  0);
    check("rst rdata",   get_rdata(0),   64'h0);
    check("rst rresp",   get_rresp(0),   0);
    check("rst rd_cnt",  rd_cnt[0],      0);

    // Reset and first fetch: cycle 0 is the first cycle with rst low
    rst = 1'b0;
    check("c0 arready", get_arready(0), 0);
    tick();
    check("c1 arready", get_arready(0), 1);
    arvalid[0] = 1'b1;
    araddr[0]  = 32'h8000_0000;
    tick();
    arvalid[0] = 1'b0;
    check("c2 rvalid",  get_rvalid(0),  0);
    check("c2 arready", get_arready(0), 0);
    tick();
    check("c3 rvalid", get_rvalid(0), 1);
    check("c3 rdata",  get_rdata(0),  D0);
    check("c3 rresp",  get_rresp(0),  0);
    rready[0] = 1'b1;
    tick();
    rready[0] = 1'b0;
    exp_cnt[0]++;
    $display("[TB] first fetch dut0 handshake done");
    check("c4 rd_cnt",  rd_cnt[0],      exp_cnt[0]);
    check("c4 rvalid",  get_rvalid(0),  0);
    check("c4 arready", get_arready(0), 1);

    // Table of single reads on the LATENCY=1 instance
    for (int i = 0; i < 9; i++) begin
      fetch(0, vecs[i].addr, d, r, lat);
      exp_cnt[0]++;
      check($sformatf("vec%0d data", i),    d,               vecs[i].data);
      check($sformatf("vec%0d resp", i),    64'(r),          64'(vecs[i].resp));
      check($sformatf("vec%0d lat", i),     64'(lat),        64'd2);
      check($sformatf("vec%0d rd_cnt", i),  rd_cnt[0],       exp_cnt[0]);
      check($sformatf("vec%0d arready", i), get_arready(0),  1);
    end

    // Back-to-back on LATENCY=0 with RREADY tied high; ARVALID stays up while ARREADY=0
    rready[1]  = 1'b1;
    arvalid[1] = 1'b1;
    araddr[1]  = 32'h8000_0000;
    tick();
    check("b2b c1 rvalid",  get_rvalid(1),  1);
    check("b2b c1 rdata",   get_rdata(1),   D0);
    check("b2b c1 arready", get_arready(1), 0);
    araddr[1] = 32'h7FFF_FFF8;
    tick();
    check("b2b c2 rvalid",  get_rvalid(1),  0);
    check("b2b c2 arready", get_arready(1), 1);
    araddr[1] = 32'h8000_0004;
    tick();
    check("b2b c3 rvalid", get_rvalid(1), 1);
    check("b2b c3 rdata",  get_rdata(1),  D0);
    check("b2b c3 rresp",  get_rresp(1),  0);
    araddr[1] = 32'h7FFF_FFF8;
    tick();
    check("b2b c4 rvalid",  get_rvalid(1),  0);
    check("b2b c4 arready", get_arready(1), 1);
    araddr[1] = 32'h8000_0008;
    tick();
    arvalid[1] = 1'b0;
    check("b2b c5 rvalid", get_rvalid(1), 1);
    check("b2b c5 rdata",  get_rdata(1),  D1);
    tick();
    rready[1] = 1'b0;
    exp_cnt[1] = 32'd3;
    $display("[TB] back-to-back dut1 three reads done");
    check("b2b rd_cnt", rd_cnt[1], exp_cnt[1]);

    // Backpressure on LATENCY=1; a preload to the held word must not disturb RDATA
    arvalid[0] = 1'b1;
    araddr[0]  = 32'h8000_0008;
    tick();
    arvalid[0] = 1'b0;
    araddr[0]  = 32'h8000_0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        ld_en   = 1'b1;
        ld_idx  = 12'd1;
        ld_data = 64'h0000ABCD_00001111;
      end
      check($sformatf("bp%0d rvalid", k),  get_rvalid(0),  1);
      check($sformatf("bp%0d rdata", k),   get_rdata(0),   D1);
      check($sformatf("bp%0d rresp", k),   get_rresp(0),   0);
      check($sformatf("bp%0d arready", k), get_arready(0), 0);
      tick();
      ld_en = 1'b0;
    end
    check("bp rvalid held", get_rvalid(0), 1);
    check("bp rdata held",  get_rdata(0),  D1);
    rready[0] = 1'b1;
    tick();
    rready[0] = 1'b0;
    exp_cnt[0]++;
    $display("[TB] backpressure dut0 handshake done");
    check("bp after arready", get_arready(0), 1);
    check("bp after rvalid",  get_rvalid(0),  0);
    check("bp after rd_cnt",  rd_cnt[0],      exp_cnt[0]);
    fetch(0, 32'h8000_0008, d, r, lat);
    exp_cnt[0]++;
    check("bp new data", d, 64'h0000ABCD_00001111);

    // Read-before-write: preload in the capture cycle is not seen by this response
    arvalid[0] = 1'b1;
    araddr[0]  = 32'h8000_0030;
    tick();
    arvalid[0] = 1'b0;
    ld_en   = 1'b1;
    ld_idx  = 12'd6;
    ld_data = 64'h00000000_00006767;
    tick();
    ld_en = 1'b0;
    check("rbw rvalid", get_rvalid(0), 1);
    check("rbw old data", get_rdata(0), D6);
    rready[0] = 1'b1;
    tick();
    rready[0] = 1'b0;
    exp_cnt[0]++;
    $display("[TB] read-before-write dut0 handshake done");
    fetch(0, 32'h8000_0030, d, r, lat);
    exp_cnt[0]++;
    check("rbw new data", d, 64'h00000000_00006767);
    check("rbw rd_cnt", rd_cnt[0], exp_cnt[0]);

    // Preload collision at the AR handshake on LATENCY=0
    arvalid[1] = 1'b1;
    araddr[1]  = 32'h8000_0028;
    ld_en   = 1'b1;
    ld_idx  = 12'd5;
    ld_data = 64'h00000000_0000DEAD;
    tick();
    ld_en      = 1'b0;
    arvalid[1] = 1'b0;
    check("col rvalid", get_rvalid(1), 1);
    check("col rdata",  get_rdata(1),  64'h00000000_0000DEAD);
    check("col rresp",  get_rresp(1),  0);
    rready[1] = 1'b1;
    tick();
    rready[1] = 1'b0;
    exp_cnt[1]++;
    $display("[TB] collision dut1 handshake done");
    check("col rd_cnt", rd_cnt[1], exp_cnt[1]);

    // Mid-transaction reset on LATENCY=4
    fetch(2, 32'h8000_0000, d, r, lat);
    exp_cnt[2]++;
    check("l4 data",   d,         D0);
    check("l4 lat",    64'(lat),  64'd5);
    check("l4 rd_cnt", rd_cnt[2], exp_cnt[2]);
    arvalid[2] = 1'b1;
    araddr[2]  = 32'h8000_0000;
    tick();
    arvalid[2] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("[TB] mid-transaction reset dut2 applied");
    check("mrst rvalid",  get_rvalid(2),  0);
    check("mrst arready", get_arready(2), 0);
    check("mrst rd_cnt",  rd_cnt[2],      0);
    check("mrst rd_cnt dut0", rd_cnt[0],  0);
    tick();
    check("mrst arready after", get_arready(2), 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (get_rvalid(2)) seen++;
      tick();
    end
    check("mrst no rvalid", 64'(seen), 64'd0);
    fetch(2, 32'h8000_0000, d, r, lat);
    check("mrst refetch data", d,         D0);
    check("mrst refetch lat",  64'(lat),  64'd5);
    check("mrst refetch cnt",  rd_cnt[2], 1);
    fetch(0, 32'h8000_0008, d, r, lat);
    check("mrst mem survives", d, 64'h0000ABCD_00001111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
